// File: rtl/pin_timing_sequencer_pkg.sv
// Shared types and constants for the PIN-guess timing sequencer.
package pin_timing_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND    = 3'd1,
    WAIT    = 3'd2,
    REPORT  = 3'd3,
    TGT_RST = 3'd4
  } state_e;

  localparam logic [7:0] CMD_RESET    = 8'h09;
  localparam logic [7:0] STAT_OK      = 8'h00;
  localparam logic [7:0] STAT_TIMEOUT = 8'hFF;

endpackage

// File: rtl/pin_timing_sequencer_uart_byte_launcher.sv
// One-byte holding register that launches its byte into a uart_tx with an
// en/rdy handshake: pulse en while rdy=1, then wait for rdy low-then-high.
module uart_byte_launcher (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       rdy,
  output logic [7:0] data,
  output logic       en,
  output logic       full,
  output logic       launch_c
);

  logic sent;
  logic seen_low;

  // Launch decision is visible one cycle before en so the owner can act on it.
  assign launch_c = full && !sent && rdy;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      data     <= 8'h00;
      en       <= 1'b0;
      full     <= 1'b0;
      sent     <= 1'b0;
      seen_low <= 1'b0;
    end else begin
      en <= launch_c;
      if (load && !full) begin
        data <= load_data;
        full <= 1'b1;
      end else if (launch_c) begin
        sent <= 1'b1;
      end else if (sent) begin
        // Byte stays held until the transmitter has visibly taken and finished it.
        if (!rdy) begin
          seen_low <= 1'b1;
        end else if (seen_low) begin
          full     <= 1'b0;
          sent     <= 1'b0;
          seen_low <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/pin_timing_sequencer.sv
// Sequences one PIN-guess measurement: forward frame, time first response, report.
// Optional macro ECHO_RESP_EN appends the first device response byte to the report.
module pin_timing_sequencer
  import pin_timing_sequencer_pkg::*;
#(
  parameter int unsigned FRAME_LEN   = 16,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned RST_CYCLES  = 1000,
  parameter int unsigned TIMEOUT_CYC = 100000000
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic [7:0] host_rx_data,
  input  logic       host_rx_valid,
  output logic [7:0] host_tx_data,
  output logic       host_tx_en,
  input  logic       host_tx_rdy,
  output logic [7:0] dev_tx_data,
  output logic       dev_tx_en,
  input  logic       dev_tx_rdy,
  input  logic [7:0] dev_rx_data,
  input  logic       dev_rx_valid,
  output logic       dev_reset_n,
  output logic       busy,
  output logic       overrun
);

  localparam int unsigned IDX_W     = $clog2(FRAME_LEN + 1);
  localparam int unsigned CNT_BYTES = CNT_W / 8;
`ifdef ECHO_RESP_EN
  localparam int unsigned REP_LEN   = CNT_BYTES + 2;
`else
  localparam int unsigned REP_LEN   = CNT_BYTES + 1;
`endif
  localparam int unsigned REP_W     = $clog2(REP_LEN + 1);

  state_e             state;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_lat;
  logic [7:0]         status;
  logic [REP_W-1:0]   rep_idx;
`ifdef ECHO_RESP_EN
  logic [7:0]         resp;
`else
  logic               dev_rx_data_unused;
  assign dev_rx_data_unused = ^dev_rx_data;
`endif

  logic       dev_load_c;
  logic       dev_full;
  logic       dev_launch_c;
  logic       host_load_c;
  logic       host_full;
  logic       host_launch_unused_c;
  logic [7:0] host_byte_c;

  // Load strobes for the two launchers.
  always_comb begin
    dev_load_c  = 1'b0;
    host_load_c = 1'b0;
    if (host_rx_valid && !dev_full) begin
      if (state == IDLE) begin
        dev_load_c = (host_rx_data != CMD_RESET);
      end else if (state == SEND) begin
        dev_load_c = (idx != IDX_W'(FRAME_LEN));
      end
    end
    if (state == REPORT && !host_full && rep_idx != REP_W'(REP_LEN)) begin
      host_load_c = 1'b1;
    end
  end

  // Report byte: count LSB first, then status, then optional echoed response.
  always_comb begin
    host_byte_c = status;
    if (rep_idx < REP_W'(CNT_BYTES)) begin
      host_byte_c = 8'(cnt_lat >> {rep_idx, 3'b000});
`ifdef ECHO_RESP_EN
    end else if (rep_idx > REP_W'(CNT_BYTES)) begin
      host_byte_c = resp;
`endif
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      cnt_lat     <= '0;
      status      <= STAT_OK;
      rep_idx     <= '0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      dev_reset_n <= 1'b1;
`ifdef ECHO_RESP_EN
      resp        <= 8'h00;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (host_rx_valid) begin
            if (host_rx_data == CMD_RESET) begin
              state       <= TGT_RST;
              busy        <= 1'b1;
              overrun     <= 1'b0;
              dev_reset_n <= 1'b0;
              cnt         <= '0;
            end else if (dev_load_c) begin
              idx   <= IDX_W'(1);
              state <= SEND;
              busy  <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end
        end
        SEND: begin
          if (host_rx_valid) begin
            if (dev_load_c) idx <= idx + IDX_W'(1);
            else            overrun <= 1'b1;
          end
          // Launching with the full frame accepted means the last byte is going out.
          if (dev_launch_c && idx == IDX_W'(FRAME_LEN)) begin
            cnt   <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (host_rx_valid) overrun <= 1'b1;
          if (dev_rx_valid) begin
            cnt_lat <= cnt;
            status  <= STAT_OK;
            rep_idx <= '0;
            state   <= REPORT;
`ifdef ECHO_RESP_EN
            resp    <= dev_rx_data;
`endif
          end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            cnt_lat <= cnt;
            status  <= STAT_TIMEOUT;
            rep_idx <= '0;
            state   <= REPORT;
`ifdef ECHO_RESP_EN
            resp    <= 8'h00;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        REPORT: begin
          if (host_rx_valid) overrun <= 1'b1;
          if (host_load_c) begin
            rep_idx <= rep_idx + REP_W'(1);
          end else if (rep_idx == REP_W'(REP_LEN) && !host_full) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        TGT_RST: begin
          if (cnt == CNT_W'(RST_CYCLES - 1)) begin
            dev_reset_n <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  uart_byte_launcher u_dev_launcher (
    .CLK       (CLK),
    .rst_n     (rst_n),
    .load      (dev_load_c),
    .load_data (host_rx_data),
    .rdy       (dev_tx_rdy),
    .data      (dev_tx_data),
    .en        (dev_tx_en),
    .full      (dev_full),
    .launch_c  (dev_launch_c)
  );

  uart_byte_launcher u_host_launcher (
    .CLK       (CLK),
    .rst_n     (rst_n),
    .load      (host_load_c),
    .load_data (host_byte_c),
    .rdy       (host_tx_rdy),
    .data      (host_tx_data),
    .en        (host_tx_en),
    .full      (host_full),
    .launch_c  (host_launch_unused_c)
  );

endmodule
